// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core types and constants for register file datapaths
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search begins just after ptr
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        // offset N revisits ptr itself, so a lone requester at ptr still wins
        for (int off = 1; off <= N; off++) begin
            idx = (int'(ptr) + off) % N;
            if (!gnt_any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
                gnt_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter feeding the single register file write port
module wb_arbiter #(
    parameter int NSRC = 2,
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int IW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NSRC-1:0]           src_valid,
    output logic [NSRC-1:0]           src_ready,
    input  logic [NSRC-1:0][4:0]      src_rd,
    input  logic [NSRC-1:0][XLEN-1:0] src_data,
    output logic                      rf_we,
    output logic [4:0]                rf_rd,
    output logic [XLEN-1:0]           rf_wdata,
    output logic [IW-1:0]             grant_idx
);

    import riscv_pkg::*;

    logic [NSRC-1:0] elig;
    logic [NSRC-1:0] x0_sink;
    logic [NSRC-1:0] gnt;
    logic [IW-1:0]   win;
    logic            gnt_any;
    logic [IW-1:0]   rr_ptr;

    always_comb begin
        elig    = '0;
        x0_sink = '0;
        for (int i = 0; i < NSRC; i++) begin
            elig[i]    = src_valid[i] && (src_rd[i] != REG_ZERO);
            x0_sink[i] = src_valid[i] && (src_rd[i] == REG_ZERO);
        end
    end

    rr_arbiter #(
        .N  (NSRC),
        .IW (IW)
    ) u_rr (
        .req     (elig),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (win),
        .gnt_any (gnt_any)
    );

    // x0 writes are discarded, so they retire without consuming the write port
    assign src_ready = rst ? '0 : (x0_sink | gnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= IW'(NSRC - 1);
            rf_we     <= 1'b0;
            rf_rd     <= '0;
            rf_wdata  <= '0;
            grant_idx <= '0;
        end else if (gnt_any) begin
            rr_ptr    <= win;
            rf_we     <= 1'b1;
            rf_rd     <= src_rd[win];
            rf_wdata  <= src_data[win];
            grant_idx <= win;
        end else begin
            rf_we     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for wb_arbiter with directed vectors
module tb_wb_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       src_valid;
    logic [1:0]       src_ready;
    logic [1:0][4:0]  src_rd;
    logic [1:0][31:0] src_data;
    logic             rf_we;
    logic [4:0]       rf_rd;
    logic [31:0]      rf_wdata;
    logic [0:0]       grant_idx;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        idx;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    wb_arbiter #(.NSRC(2), .XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_rd    (src_rd),
        .src_data  (src_data),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_wdata  (rf_wdata),
        .grant_idx (grant_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Drive one cycle of requests starting just after a rising edge; push the write expected after the edge.
    task automatic cyc(input string name, input logic [1:0] v,
                       input logic [4:0] r0, input logic [31:0] d0,
                       input logic [4:0] r1, input logic [31:0] d1,
                       input logic [1:0] exp_ready, input bit push,
                       input logic [4:0] prd, input logic [31:0] pdata, input logic pidx);
        exp_t e;
        src_valid   = v;
        src_rd[0]   = r0;
        src_data[0] = d0;
        src_rd[1]   = r1;
        src_data[1] = d1;
        #1;
        chk({name, "_ready"}, 64'(src_ready), 64'(exp_ready));
        @(posedge clk);
        if (push) begin
            e.rd   = prd;
            e.data = pdata;
            e.idx  = pidx;
            exp_q.push_back(e);
        end
        #1;
    endtask

    task automatic idle(input string name);
        cyc(name, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 2'b00, 1'b0, 5'd0, 32'd0, 1'b0);
    endtask

    // Monitor: every write the DUT presents must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rf_we) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write_rd", 64'(rf_rd), 64'h3f);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_rd", 64'(rf_rd), 64'(e.rd));
                        chk("wr_data", 64'(rf_wdata), 64'(e.data));
                        chk("wr_idx", 64'(grant_idx), 64'(e.idx));
                    end
                end else if (exp_q.size() != 0) begin
                    chk("missing_write", 64'(rf_we), 64'd1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst         = 1'b1;
        src_valid   = 2'b11;
        src_rd[0]   = 5'd3;
        src_rd[1]   = 5'd7;
        src_data[0] = 32'h1;
        src_data[1] = 32'h2;
        @(posedge clk);
        #1;
        chk("rst_we", 64'(rf_we), 64'd0);
        chk("rst_rd", 64'(rf_rd), 64'd0);
        chk("rst_wdata", 64'(rf_wdata), 64'd0);
        chk("rst_gidx", 64'(grant_idx), 64'd0);
        chk("rst_ready", 64'(src_ready), 64'd0);
        rst = 1'b0;

        // single write from source 0, visible the cycle after acceptance
        cyc("single", 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 2'b01, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
        idle("single_gap");
        chk("single_we_drop", 64'(rf_we), 64'd0);

        // x0 from source 0 retires alongside the source 1 grant; ptr -> 1
        cyc("x0", 2'b11, 5'd0, 32'hCAFE, 5'd9, 32'h99, 2'b11, 1'b1, 5'd9, 32'h99, 1'b1);

        // both held valid: 0,1,0,1,0,1
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0)
                cyc("alt", 2'b11, 5'd3, 32'h33, 5'd7, 32'h77, 2'b01, 1'b1, 5'd3, 32'h33, 1'b0);
            else
                cyc("alt", 2'b11, 5'd3, 32'h33, 5'd7, 32'h77, 2'b10, 1'b1, 5'd7, 32'h77, 1'b1);
        end

        // ptr is 1; a lone source 0 write moves it to 0
        cyc("setptr", 2'b01, 5'd1, 32'h01, 5'd0, 32'd0, 2'b01, 1'b1, 5'd1, 32'h01, 1'b0);

        // same rd: source 1 first, then source 0
        cyc("samerd_a", 2'b11, 5'd4, 32'h11, 5'd4, 32'h22, 2'b10, 1'b1, 5'd4, 32'h22, 1'b1);
        cyc("samerd_b", 2'b01, 5'd4, 32'h11, 5'd4, 32'h22, 2'b01, 1'b1, 5'd4, 32'h11, 1'b0);

        // idle: outputs hold the last write
        for (int k = 0; k < 10; k++) begin
            idle("hold");
            chk("hold_we", 64'(rf_we), 64'd0);
        end
        chk("hold_rd", 64'(rf_rd), 64'd4);
        chk("hold_wdata", 64'(rf_wdata), 64'h11);
        chk("hold_gidx", 64'(grant_idx), 64'd0);

        // reset while a write is pending; ptr was 0 so without reset source 1 would win next
        cyc("prerst", 2'b01, 5'd2, 32'hAB, 5'd0, 32'd0, 2'b01, 1'b0, 5'd0, 32'd0, 1'b0);
        chk("prerst_we", 64'(rf_we), 64'd1);
        chk("prerst_rd", 64'(rf_rd), 64'd2);
        rst         = 1'b1;
        src_valid   = 2'b11;
        src_rd[0]   = 5'd6;
        src_data[0] = 32'h66;
        src_rd[1]   = 5'd8;
        src_data[1] = 32'h88;
        #1;
        chk("midrst_we", 64'(rf_we), 64'd0);
        chk("midrst_rd", 64'(rf_rd), 64'd0);
        chk("midrst_wdata", 64'(rf_wdata), 64'd0);
        chk("midrst_gidx", 64'(grant_idx), 64'd0);
        chk("midrst_ready", 64'(src_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("postrst", 2'b11, 5'd6, 32'h66, 5'd8, 32'h88, 2'b01, 1'b1, 5'd6, 32'h66, 1'b0);
        cyc("postrst2", 2'b10, 5'd6, 32'h66, 5'd8, 32'h88, 2'b10, 1'b1, 5'd8, 32'h88, 1'b1);
        idle("tail");
        idle("tail");

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
